// File: rtl/startup_reset_seq.sv
// Power-up reset sequencer: pulses the clock-wizard reset, waits for lock, then releases channels in order.
// Define STARTUP_SEQ_RETRY_EN to re-pulse the wizard on lock timeout instead of faulting.
module startup_reset_seq #(
  parameter int NCH            = 2,
  parameter int PLL_RST_CYCLES = 5,
  parameter int LOCK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES  = 10,
  parameter int STAGGER        = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_locked,
  output logic           o_rst_clk,
  output logic [NCH-1:0] o_rst,
  output logic           o_ready,
  output logic [3:0]     o_retry_cnt,
  output logic           o_lock_lost,
  output logic           o_err
);

  localparam int M1      = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int M2      = (STAGGER * NCH > PLL_RST_CYCLES) ? STAGGER * NCH : PLL_RST_CYCLES;
  localparam int MAX_CNT = (M1 > M2) ? M1 : M2;
  localparam int CW      = $clog2(MAX_CNT + 1);

  // PLLRST counts one extra step so the pulse length is exact both out of reset and on retry.
  localparam logic [CW-1:0] PLL_TERM    = CW'(PLL_RST_CYCLES);
  localparam logic [CW-1:0] LOCK_TERM   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_TERM = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_TERM    = CW'(STAGGER * (NCH - 1));

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT,
    ST_SETTLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [1:0]     sync_reg;
  logic           locked;
  logic           rst_clk_reg, rst_clk_next;
  logic [NCH-1:0] rst_reg, rst_next;
  logic           ready_reg, ready_next;
  logic [3:0]     retry_reg, retry_next;
  logic           lost_reg, lost_next;
  logic           err_reg, err_next;
  logic [NCH-1:0] release_hit;

  assign locked = sync_reg[1];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync_reg    <= 2'b00;
      state_reg   <= ST_PLLRST;
      cnt_reg     <= '0;
      rst_clk_reg <= 1'b0;
      rst_reg     <= '1;
      ready_reg   <= 1'b0;
      retry_reg   <= 4'd0;
      lost_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], i_locked};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rst_clk_reg <= rst_clk_next;
      rst_reg     <= rst_next;
      ready_reg   <= ready_next;
      retry_reg   <= retry_next;
      lost_reg    <= lost_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_PLLRST: begin
        if (cnt_reg == PLL_TERM) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_WAIT: begin
        if (locked) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end else if (cnt_reg == LOCK_TERM) begin
`ifdef STARTUP_SEQ_RETRY_EN
          state_next = ST_PLLRST;
          cnt_next   = CW'(1);
          if (retry_reg != 4'd15) begin
            retry_next = retry_reg + 4'd1;
          end
`else
          state_next = ST_FAULT;
          cnt_next   = '0;
          err_next   = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (!locked) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == SETTLE_TERM) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (!locked) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
          lost_next  = 1'b1;
        end else if (cnt_reg == REL_TERM) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_RUN: begin
        if (!locked) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
          lost_next  = 1'b1;
        end
      end
      ST_FAULT: begin
        retry_next = 4'd0;
      end
      default: begin
        state_next = ST_PLLRST;
        cnt_next   = '0;
      end
    endcase
  end

  // Channel k drops on the edge where the release counter reaches STAGGER*k.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_hit
    localparam logic [CW-1:0] AT = CW'(STAGGER * gi);
    assign release_hit[gi] = (cnt_next == AT);
  end

  always_comb begin
    rst_clk_next = (state_next == ST_PLLRST);
    ready_next   = (state_next == ST_RUN);
    rst_next     = '1;
    if (state_next == ST_RELEASE) begin
      rst_next = rst_reg & ~release_hit;
    end else if (state_next == ST_RUN) begin
      rst_next = '0;
    end
  end

  assign o_rst_clk   = rst_clk_reg;
  assign o_rst       = rst_reg;
  assign o_ready     = ready_reg;
  assign o_retry_cnt = retry_reg;
  assign o_lock_lost = lost_reg;
  assign o_err       = err_reg;

endmodule

// File: tb/tb_startup_reset_seq.sv
// Directed bench for startup_reset_seq with NCH=2 and default timing parameters.
// Builds with or without STARTUP_SEQ_RETRY_EN; the timeout section follows the macro.
module tb_startup_reset_seq;

  logic       i_clk;
  logic       i_reset;
  logic       i_locked;
  logic       o_rst_clk;
  logic [1:0] o_rst;
  logic       o_ready;
  logic [3:0] o_retry_cnt;
  logic       o_lock_lost;
  logic       o_err;

  int n_vec  = 0;
  int n_miss = 0;

  startup_reset_seq #(
    .NCH(2), .PLL_RST_CYCLES(5), .LOCK_TIMEOUT(64), .SETTLE_CYCLES(10), .STAGGER(4)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_locked(i_locked),
    .o_rst_clk(o_rst_clk),
    .o_rst(o_rst),
    .o_ready(o_ready),
    .o_retry_cnt(o_retry_cnt),
    .o_lock_lost(o_lock_lost),
    .o_err(o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("  pass %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Tick n edges after reset release; report first edge with o_rst_clk high and total high edges.
  task automatic count_pulse(input int n, output int first, output int highs);
    first = -1;
    highs = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (o_rst_clk) begin
        highs++;
        if (first < 0) first = k;
      end
    end
  endtask

  // Called right after i_locked rises; measures release edges relative to that rise.
  task automatic watch_release(input string tag, input bit full);
    int n0, n1, nr;
    bit clk_seen;
    n0 = -1; n1 = -1; nr = -1; clk_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (o_rst_clk) clk_seen = 1'b1;
      if (n0 < 0 && !o_rst[0]) begin
        n0 = k;
        check_val({tag, "_rst_at_first_fall"}, o_rst, 2'b10);
      end
      if (n1 < 0 && !o_rst[1]) n1 = k;
      if (nr < 0 && o_ready) nr = k;
      if (!full && n0 >= 0) break;
    end
    check_val({tag, "_rst0_fall_edge"}, n0, 13);
    if (full) begin
      check_val({tag, "_rst1_fall_edge"}, n1, 17);
      check_val({tag, "_ready_edge"}, nr, 18);
      check_val({tag, "_rst_run"}, o_rst, 2'b00);
    end
    check_val({tag, "_no_pll_pulse"}, clk_seen, 1'b0);
  endtask

  initial begin
    int first, highs;
    i_reset  = 1'b0;
    i_locked = 1'b0;
    repeat (3) tick();
    check_val("rst_rst_clk", o_rst_clk, 1'b0);
    check_val("rst_rst", o_rst, 2'b11);
    check_val("rst_ready", o_ready, 1'b0);
    check_val("rst_retry", o_retry_cnt, 4'd0);
    check_val("rst_lost", o_lock_lost, 1'b0);
    check_val("rst_err", o_err, 1'b0);

    // Nominal bring-up
    i_reset = 1'b1;
    count_pulse(20, first, highs);
    check_val("nom_pll_first", first, 1);
    check_val("nom_pll_width", highs, 5);
    check_val("nom_rst_before_lock", o_rst, 2'b11);
    i_locked = 1'b1;
    watch_release("nom", 1'b1);
    check_val("nom_retry", o_retry_cnt, 4'd0);
    check_val("nom_lost", o_lock_lost, 1'b0);
    check_val("nom_err", o_err, 1'b0);

    // Lock loss in RUN, then re-lock
    i_locked = 1'b0;
    repeat (2) tick();
    check_val("loss_ready_2cyc", o_ready, 1'b1);
    tick();
    check_val("loss_rst", o_rst, 2'b11);
    check_val("loss_ready", o_ready, 1'b0);
    check_val("loss_lost", o_lock_lost, 1'b1);
    i_locked = 1'b1;
    watch_release("relock", 1'b1);
    check_val("relock_lost_sticky", o_lock_lost, 1'b1);

    // Reset while channel 1 still held
    i_locked = 1'b0;
    repeat (3) tick();
    i_locked = 1'b1;
    watch_release("midrel", 1'b0);
    i_reset  = 1'b0;
    i_locked = 1'b0;
    tick();
    check_val("midrel_rst", o_rst, 2'b11);
    check_val("midrel_lost", o_lock_lost, 1'b0);
    check_val("midrel_retry", o_retry_cnt, 4'd0);
    check_val("midrel_rst_clk", o_rst_clk, 1'b0);
    check_val("midrel_ready", o_ready, 1'b0);
    tick();
    i_reset = 1'b1;
    count_pulse(20, first, highs);
    check_val("midrel_pll_first", first, 1);
    check_val("midrel_pll_width", highs, 5);

    // Settle glitch: 6 high, 1 low, high again
    i_locked = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("glitch_rst_hold_a", o_rst, 2'b11);
    end
    i_locked = 1'b0;
    tick();
    check_val("glitch_rst_hold_b", o_rst, 2'b11);
    i_locked = 1'b1;
    watch_release("glitch", 1'b1);

    // Lock never arrives
    i_reset  = 1'b0;
    i_locked = 1'b0;
    repeat (2) tick();
    i_reset = 1'b1;
`ifdef STARTUP_SEQ_RETRY_EN
    begin
      int rises, bad, total_high;
      bit prev;
      rises = 0; bad = 0; total_high = 0; prev = 1'b0;
      for (int n = 1; n <= 1105; n++) begin
        tick();
        if (o_rst_clk) total_high++;
        if (o_rst_clk && !prev) begin
          rises++;
          if ((n - 1) % 69 != 0) bad++;
        end
        prev = o_rst_clk;
        if (n == 70) begin
          check_val("to_retry_1", o_retry_cnt, 4'd1);
          check_val("to_repulse", o_rst_clk, 1'b1);
        end
        if (n == 1036) check_val("to_retry_15", o_retry_cnt, 4'd15);
        if (n == 1105) begin
          check_val("to_retry_sat", o_retry_cnt, 4'd15);
          check_val("to_last_pulse", o_rst_clk, 1'b1);
        end
      end
      check_val("to_rises", rises, 17);
      check_val("to_rise_spacing", bad, 0);
      check_val("to_high_edges", total_high, 81);
      check_val("to_err", o_err, 1'b0);
      check_val("to_rst", o_rst, 2'b11);
    end
`else
    begin
      int pulses;
      pulses = 0;
      for (int n = 1; n <= 70; n++) begin
        tick();
        if (o_rst_clk) pulses++;
        if (n == 69) check_val("to_err_early", o_err, 1'b0);
        if (n == 70) check_val("to_err_set", o_err, 1'b1);
      end
      check_val("to_pll_highs", pulses, 5);
      check_val("to_rst_clk", o_rst_clk, 1'b0);
      check_val("to_rst", o_rst, 2'b11);
      i_locked = 1'b1;
      repeat (20) tick();
      check_val("fault_err_hold", o_err, 1'b1);
      check_val("fault_rst_hold", o_rst, 2'b11);
      check_val("fault_ready", o_ready, 1'b0);
      check_val("fault_rst_clk", o_rst_clk, 1'b0);
      check_val("fault_retry", o_retry_cnt, 4'd0);
      i_reset = 1'b0;
      tick();
      check_val("fault_reset_err", o_err, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/startup_reset_seq.md
STARTUP_RESET_SEQ -- requirements
Module: startup_reset_seq

Interface
REQ-001 SHALL have parameter NCH, default 2: number of downstream reset channels (1..8).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 5: cycles o_rst_clk is held high per pulse.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 64: cycles allowed in WAIT for lock.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 10: consecutive locked cycles required before release.
REQ-005 SHALL have parameter STAGGER, default 4: cycles between successive channel releases.
REQ-006 SHALL have port i_clk  input  1: the only clock; all logic on rising edge.
REQ-007 SHALL have port i_reset  input  1: synchronous, active-low reset.
REQ-008 SHALL have port i_locked  input  1: clock-wizard lock, asynchronous to i_clk.
REQ-009 SHALL have port o_rst_clk  output  1: active-high reset to the clock wizard.
REQ-010 SHALL have port o_rst  output  NCH: active-high per-channel system resets.
REQ-011 SHALL have port o_ready  output  1: high only in RUN.
REQ-012 SHALL have port o_retry_cnt  output  4: lock-timeout retries, saturating at 15.
REQ-013 SHALL have port o_lock_lost  output  1: sticky, set on lock loss after release began.
REQ-014 SHALL have port o_err  output  1: sticky fault flag (see Configuration).

Function
REQ-015 SHALL register all outputs; i_locked SHALL pass a 2-flop synchronizer, and "locked" below means the synchronized value.
REQ-016 SHALL implement states PLLRST, WAIT, SETTLE, RELEASE, RUN, FAULT; reset target is PLLRST.
REQ-017 PLLRST: o_rst_clk=1 for exactly PLL_RST_CYCLES cycles and o_rst all ones, then WAIT.
REQ-018 WAIT: o_rst_clk=0; locked=1 moves to SETTLE; LOCK_TIMEOUT cycles with no lock counts as a timeout (REQ-029/030).
REQ-019 SETTLE: locked=0 on any cycle returns to WAIT with all counters cleared; SETTLE_CYCLES consecutive locked cycles move to RELEASE.
REQ-020 RELEASE: o_rst[0] SHALL fall on entry and o_rst[k] STAGGER*k cycles later, channel 0 first.
REQ-021 RELEASE SHALL enter RUN one cycle after o_rst[NCH-1] falls; o_ready=1 in RUN.
REQ-022 In RELEASE or RUN, locked=0 SHALL on the next edge set all o_rst, clear o_ready, set o_lock_lost and go to WAIT without a PLLRST pulse.
REQ-023 Once deasserted, o_rst[k] SHALL not reassert except per REQ-022 or reset.
REQ-024 o_retry_cnt SHALL increment once per timeout and SHALL hold at 15 (no wrap).
REQ-025 Counters SHALL be sized by $clog2 of the largest of LOCK_TIMEOUT, SETTLE_CYCLES, STAGGER*NCH, PLL_RST_CYCLES, and SHALL not overflow.

Reset
REQ-026 On a rising edge with i_reset=0: o_rst_clk=0, o_rst all ones, o_ready=0, o_retry_cnt=0, o_lock_lost=0, o_err=0, synchronizer cleared, state PLLRST with counter 0.
REQ-027 The first o_rst_clk=1 cycle SHALL be the cycle after the first edge with i_reset=1.
REQ-028 Reset asserted in any state, including mid-RELEASE, SHALL take effect on that edge and override all other events.

Configuration
REQ-029 With STARTUP_SEQ_RETRY_EN defined, a WAIT timeout SHALL increment o_retry_cnt and return to PLLRST, issuing a new o_rst_clk pulse.
REQ-030 Without STARTUP_SEQ_RETRY_EN, a WAIT timeout SHALL set o_err=1 and enter FAULT; FAULT holds o_rst_clk=0, o_rst all ones and o_retry_cnt=0, and exits only by reset.

Verification (NCH=2, defaults)
REQ-031 Nominal: i_reset low 3 cycles then high; i_locked rises 20 cycles later -> o_rst_clk high exactly 5 cycles; o_rst[0] falls 2+10 cycles after the i_locked edge (+/-1 for sync); o_rst[1] falls 4 cycles later; o_ready rises 1 cycle after that; o_retry_cnt=0.
REQ-032 Settle glitch: i_locked high 6 cycles, low 1, high again -> no o_rst change; o_rst[0] falls 10 synchronized cycles after the second rise.
REQ-033 Timeout, with macro: i_locked held 0 -> o_rst_clk pulses of 5 cycles spaced 5+64 cycles apart; o_retry_cnt counts 1..15 and holds at 15. Without macro: o_err=1 after 69 cycles; o_rst_clk stays 0.
REQ-034 Lock loss in RUN: drop i_locked -> both o_rst=1 and o_ready=0 within 3 cycles, o_lock_lost=1; re-lock -> full settle/stagger sequence with no o_rst_clk pulse.
REQ-035 Reset mid-RELEASE: i_reset=0 while o_rst=2'b10 -> next edge o_rst=2'b11, o_lock_lost=0, o_retry_cnt=0, o_rst_clk=0.
